debugger_tx: RTL

DEBUGGER_TX -- requirements
Module: debugger_tx

---
 rtl/debugger_tx_if.sv | 22 ++
 rtl/debugger_tx.sv | 112 +++++++++++
 2 files changed

// File: rtl/debugger_tx_if.sv
// rtl/debugger_tx_if.sv - frame request / UART TX FIFO write bundle for debugger_tx
interface debugger_tx_if #(
    parameter int DATA_W = 1720
);
    logic              send_signal;
    logic [DATA_W-1:0] sendData;
    logic              tx_full;
    logic [7:0]        w_data;
    logic              wr_uart;
    logic              busy;
    logic              data_sent;

    modport master (
        output send_signal, sendData, tx_full,
        input  w_data, wr_uart, busy, data_sent
    );

    modport slave (
        input  send_signal, sendData, tx_full,
        output w_data, wr_uart, busy, data_sent
    );
endinterface

// File: rtl/debugger_tx.sv
// rtl/debugger_tx.sv - serialises a NUM_BYTES frame MSB-byte first into a UART TX FIFO
// Optional trailing modulo-256 checksum byte when DEBUGGER_TX_CHECKSUM_EN is defined.
module debugger_tx #(
    parameter int NUM_BYTES = 215,
    parameter int DATA_W    = 8 * NUM_BYTES
) (
    input  logic         clk,
    input  logic         global_reset,
    debugger_tx_if.slave bus
);
`ifdef DEBUGGER_TX_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_BYTES + 1;
`else
    localparam int FRAME_LEN = NUM_BYTES;
`endif
    localparam int               CNT_W    = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_data_sent;
    logic              w_wr;
    logic              w_accept;
    logic              w_last_wr;
    logic [7:0]        w_top;
    logic [7:0]        w_byte;

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_wr     = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.send_signal) begin
                    w_accept = 1'b1;
                    w_next   = S_SEND;
                end
            end
            S_SEND: begin
                w_wr = ~bus.tx_full;
                if (w_wr && (r_cnt == LAST_IDX)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_last_wr = w_wr && (r_cnt == LAST_IDX);
    assign w_top     = r_shift[DATA_W-1 -: 8];

    // Counter parks on the last index so it never needs a wider range than NUM_BYTES.
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_data_sent <= 1'b0;
        end else begin
            r_data_sent <= w_last_wr;
            if (w_accept) begin
                r_shift <= bus.sendData;
                r_cnt   <= '0;
            end else if (w_wr) begin
                r_shift <= {r_shift[DATA_W-9:0], 8'h00};
                if (r_cnt != LAST_IDX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef DEBUGGER_TX_CHECKSUM_EN
    localparam logic [CNT_W-1:0] CK_IDX = CNT_W'(NUM_BYTES);
    logic [7:0] r_sum;

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            r_sum <= 8'h00;
        end else if (w_accept) begin
            r_sum <= 8'h00;
        end else if (w_wr && (r_cnt != CK_IDX)) begin
            r_sum <= r_sum + w_top;
        end
    end

    assign w_byte = ((r_state == S_SEND) && (r_cnt == CK_IDX)) ? r_sum : w_top;
`else
    assign w_byte = w_top;
`endif

    assign bus.w_data    = w_byte;
    assign bus.wr_uart   = w_wr;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.data_sent = r_data_sent;
endmodule
